// File: rtl/blink_monitor.sv
// blink_monitor: receive-side checker for a periodic LED toggle stream.
// Synchronises the asynchronous toggle input, measures edge-to-edge intervals,
// locks after LockCount consecutive in-tolerance intervals and then latches a
// sticky fault on any out-of-tolerance interval or a missing edge.
module blink_monitor #(
  parameter int unsigned CyclesPerToggle = 100,
  parameter int unsigned Tolerance       = 2,
  parameter int unsigned LockCount       = 4,
  parameter int unsigned CountWidth      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  led_i,
  input  logic                  clear_i,
  output logic [CountWidth-1:0] period_o,
  output logic                  period_valid_o,
  output logic                  locked_o,
  output logic                  err_o,
  output logic [15:0]           edge_count_o
);

  // One extra bit so cnt+1 never wraps before the tolerance compare.
  localparam int unsigned MeasWidth = CountWidth + 1;
  localparam logic [MeasWidth-1:0] PeriodHi =
    MeasWidth'(CyclesPerToggle + Tolerance);
  // Lower bound clamps to zero when the tolerance swallows the nominal period.
  localparam logic [MeasWidth-1:0] PeriodLo =
    (Tolerance >= CyclesPerToggle) ? '0 : MeasWidth'(CyclesPerToggle - Tolerance);
  localparam logic [CountWidth-1:0] TimeoutCnt =
    CountWidth'(CyclesPerToggle + Tolerance);
  localparam int unsigned GoodWidth = $clog2(LockCount + 1);
  localparam logic [GoodWidth-1:0] GoodLast = GoodWidth'(LockCount - 1);

  typedef enum logic [1:0] {
    SEEK    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2,
    FAULT   = 2'd3
  } state_t;

  state_t                 state;
  logic                   s1, s2, s3;
  logic                   led_edge;
  logic [CountWidth-1:0]  cnt;
  logic [MeasWidth-1:0]   measured;
  logic                   in_tol;
  logic                   timeout;
  logic [GoodWidth-1:0]   good;

  // Three-flop chain: s1/s2 resolve metastability, s3 holds the previous level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      // NOTE: non-blocking so each stage takes the previous stage's old value;
      // blocking assignments here would collapse the chain into a single flop.
      s1 <= led_i;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign led_edge = s2 ^ s3;

  // Interval decode: measured period, tolerance window and missing-edge timeout.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    measured = '0;
    in_tol   = 1'b0;
    timeout  = 1'b0;
    measured = {1'b0, cnt} + MeasWidth'(1);
    in_tol   = (measured >= PeriodLo) && (measured <= PeriodHi);
    timeout  = !led_edge && (cnt == TimeoutCnt);
  end

  // Cycles since last edge; held at zero while searching, saturates at all-ones.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
    end else if (clear_i || state == SEEK || led_edge) begin
      cnt <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Total synchronised edges in every state, including a clear cycle; wraps.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      edge_count_o <= '0;
    end else if (led_edge) begin
      edge_count_o <= edge_count_o + 16'd1;
    end
  end

  // Lock FSM with registered status outputs; clear overrides everything.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= SEEK;
      good           <= '0;
      period_o       <= '0;
      period_valid_o <= 1'b0;
      locked_o       <= 1'b0;
      err_o          <= 1'b0;
    end else begin
      period_valid_o <= 1'b0;
      if (clear_i) begin
        state    <= SEEK;
        good     <= '0;
        locked_o <= 1'b0;
        err_o    <= 1'b0;
      end else begin
        case (state)
          SEEK: begin
            good <= '0;
            if (led_edge) state <= MEASURE;
          end
          MEASURE: begin
            if (led_edge) begin
              period_o       <= measured[CountWidth-1:0];
              period_valid_o <= 1'b1;
              if (!in_tol) begin
                good <= '0;
              end else if (good == GoodLast) begin
                good     <= '0;
                state    <= LOCKED;
                locked_o <= 1'b1;
              end else begin
                good <= good + 1'b1;
              end
            end else if (timeout) begin
              good  <= '0;
              state <= SEEK;
            end
          end
          LOCKED: begin
            if (led_edge) begin
              period_o       <= measured[CountWidth-1:0];
              period_valid_o <= 1'b1;
              if (!in_tol) begin
                state    <= FAULT;
                locked_o <= 1'b0;
                err_o    <= 1'b1;
              end
            end else if (timeout) begin
              state    <= FAULT;
              locked_o <= 1'b0;
              err_o    <= 1'b1;
            end
          end
          FAULT: begin
            locked_o <= 1'b0;
            err_o    <= 1'b1;
          end
          default: state <= SEEK;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_blink_monitor.sv
// tb_blink_monitor: directed bench for blink_monitor. Drives the toggle input
// at chosen intervals and compares every status output against hand-derived
// expectations (lock, fault, timeout, clear, async reset).
module tb_blink_monitor;

  logic        clk_i;
  logic        rst_ni;
  logic        led_i;
  logic        clear_i;
  logic [15:0] period_o;
  logic        period_valid_o;
  logic        locked_o;
  logic        err_o;
  logic [15:0] edge_count_o;

  int n_checks;
  int n_fail;
  int exp_edges;

  blink_monitor #(
    .CyclesPerToggle(100),
    .Tolerance      (2),
    .LockCount      (4),
    .CountWidth     (16)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .led_i         (led_i),
    .clear_i       (clear_i),
    .period_o      (period_o),
    .period_valid_o(period_valid_o),
    .locked_o      (locked_o),
    .err_o         (err_o),
    .edge_count_o  (edge_count_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_status(input string tag, input bit exp_valid, input int exp_period,
                              input bit exp_locked, input bit exp_err);
    check({tag, "_valid"},  32'(period_valid_o), 32'(exp_valid));
    check({tag, "_period"}, 32'(period_o),       32'(exp_period));
    check({tag, "_locked"}, 32'(locked_o),       32'(exp_locked));
    check({tag, "_err"},    32'(err_o),          32'(exp_err));
    check({tag, "_edges"},  32'(edge_count_o),   32'(exp_edges & 16'hFFFF));
  endtask

  // Entered at posedge+1, four clocks after the previous toggle. Toggles led_i
  // exactly n clocks after the previous toggle, checks the status the clock
  // after the edge is registered (3 clocks after the toggle), then checks the
  // valid pulse dropped, leaving the bench at posedge+1 again.
  task automatic step(input string tag, input int n, input bit exp_valid, input int exp_period,
                      input bit exp_locked, input bit exp_err);
    repeat (n - 4) @(posedge clk_i);
    #1 led_i = ~led_i;
    exp_edges++;
    repeat (3) @(posedge clk_i);
    #1;
    check_status(tag, exp_valid, exp_period, exp_locked, exp_err);
    @(posedge clk_i);
    #1;
    check({tag, "_valid_drop"}, 32'(period_valid_o), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    exp_edges = 0;
    rst_ni    = 1'b1;
    led_i     = 1'b0;
    clear_i   = 1'b0;
    #2 rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check_status("reset", 1'b0, 0, 1'b0, 1'b0);
    rst_ni = 1'b1;

    // 1: steady 100-cycle toggling locks one clock after the 5th edge
    step("t1_e1", 20,  1'b0, 0,   1'b0, 1'b0);
    step("t1_e2", 100, 1'b1, 100, 1'b0, 1'b0);
    step("t1_e3", 100, 1'b1, 100, 1'b0, 1'b0);
    step("t1_e4", 100, 1'b1, 100, 1'b0, 1'b0);
    step("t1_e5", 100, 1'b1, 100, 1'b1, 1'b0);

    // 2: 102 and 98 are at the window edges; 103 faults, period then frozen
    step("t2_102", 102, 1'b1, 102, 1'b1, 1'b0);
    step("t2_98",  98,  1'b1, 98,  1'b1, 1'b0);
    step("t2_103", 103, 1'b1, 103, 1'b0, 1'b1);
    step("t2_f1",  100, 1'b0, 103, 1'b0, 1'b1);
    step("t2_f2",  100, 1'b0, 103, 1'b0, 1'b1);

    // 5: clear coincident with an edge: edge counted, no measurement started
    repeat (96) @(posedge clk_i);
    #1 led_i = ~led_i;
    exp_edges++;
    repeat (2) @(posedge clk_i);
    #1 clear_i = 1'b1;
    @(posedge clk_i);
    #1 clear_i = 1'b0;
    check_status("t5_clr", 1'b0, 103, 1'b0, 1'b0);
    @(posedge clk_i);
    #1;
    step("t5_e1", 100, 1'b0, 103, 1'b0, 1'b0);
    step("t5_e2", 100, 1'b1, 100, 1'b0, 1'b0);
    step("t5_e3", 100, 1'b1, 100, 1'b0, 1'b0);
    step("t5_e4", 100, 1'b1, 100, 1'b0, 1'b0);
    step("t5_e5", 100, 1'b1, 100, 1'b1, 1'b0);

    // 3: static input while locked; edge registered 3 clocks after the toggle,
    // cnt reaches 102 at T+105 and err rises after posedge T+106
    repeat (101) @(posedge clk_i);
    #1;
    check("t3_pre_err",    32'(err_o),    32'd0);
    check("t3_pre_locked", 32'(locked_o), 32'd1);
    @(posedge clk_i);
    #1;
    check("t3_err",    32'(err_o),    32'd1);
    check("t3_locked", 32'(locked_o), 32'd0);

    // plain clear out of FAULT
    clear_i = 1'b1;
    @(posedge clk_i);
    #1 clear_i = 1'b0;
    check_status("clr", 1'b0, 100, 1'b0, 1'b0);

    // 4: a 90-cycle interval resets the good count before lock
    step("t4_e1",  20,  1'b0, 100, 1'b0, 1'b0);
    step("t4_100", 100, 1'b1, 100, 1'b0, 1'b0);
    step("t4_100", 100, 1'b1, 100, 1'b0, 1'b0);
    step("t4_90",  90,  1'b1, 90,  1'b0, 1'b0);
    step("t4_g1",  100, 1'b1, 100, 1'b0, 1'b0);
    step("t4_g2",  100, 1'b1, 100, 1'b0, 1'b0);
    step("t4_g3",  100, 1'b1, 100, 1'b0, 1'b0);
    step("t4_g4",  100, 1'b1, 100, 1'b1, 1'b0);

    // 6: async reset while locked clears outputs without a clock edge
    repeat (30) @(posedge clk_i);
    #3 rst_ni = 1'b0;
    led_i     = 1'b0;
    exp_edges = 0;
    #1;
    check_status("t6_rst", 1'b0, 0, 1'b0, 1'b0);
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    step("t6_e1", 10,  1'b0, 0,   1'b0, 1'b0);
    step("t6_e2", 100, 1'b1, 100, 1'b0, 1'b0);
    step("t6_e3", 100, 1'b1, 100, 1'b0, 1'b0);
    step("t6_e4", 100, 1'b1, 100, 1'b0, 1'b0);
    step("t6_e5", 100, 1'b1, 100, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
